// File: rtl/attn_pkg.sv
// Shared types and load-map helpers for the attention-core host bridge.
package attn_pkg;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_START  = 2'd1,
        S_WAIT   = 2'd2,
        S_STREAM = 2'd3
    } host_state_t;

    typedef enum logic [2:0] {
        SEG_X  = 3'd0,
        SEG_WQ = 3'd1,
        SEG_WK = 3'd2,
        SEG_WV = 3'd3,
        SEG_WO = 3'd4
    } seg_t;

    // Words per job: x block followed by four square weight blocks.
    function automatic int n_in(input int l, input int e);
        return l * e + 4 * e * e;
    endfunction

    function automatic int wq_base(input int l, input int e);
        return l * e;
    endfunction

    function automatic int wk_base(input int l, input int e);
        return wq_base(l, e) + e * e;
    endfunction

    function automatic int wv_base(input int l, input int e);
        return wk_base(l, e) + e * e;
    endfunction

    function automatic int wo_base(input int l, input int e);
        return wv_base(l, e) + e * e;
    endfunction

    // Offsets at the default geometry (L=8, E=8).
    localparam int L_DEF   = 8;
    localparam int E_DEF   = 8;
    localparam int X_BASE  = 0;
    localparam int WQ_BASE = L_DEF * E_DEF;
    localparam int WK_BASE = WQ_BASE + E_DEF * E_DEF;
    localparam int WV_BASE = WK_BASE + E_DEF * E_DEF;
    localparam int WO_BASE = WV_BASE + E_DEF * E_DEF;

endpackage

// File: rtl/attn_seg_decode.sv
// Maps the load beat counter to the target register array and the slot inside it.
module attn_seg_decode
    import attn_pkg::*;
#(
    parameter int L  = 8,
    parameter int E  = 8,
    parameter int CW = 9,
    parameter int IW = 6
) (
    input  logic [CW-1:0] cnt,
    output seg_t          seg,
    output logic [IW-1:0] idx
);

    localparam logic [CW-1:0] WQ_B = CW'(wq_base(L, E));
    localparam logic [CW-1:0] WK_B = CW'(wk_base(L, E));
    localparam logic [CW-1:0] WV_B = CW'(wv_base(L, E));
    localparam logic [CW-1:0] WO_B = CW'(wo_base(L, E));

    // Highest base not above the counter wins; index is the offset from that base.
    always_comb begin
        seg = SEG_X;
        idx = '0;
        if (cnt >= WO_B) begin
            seg = SEG_WO;
            idx = IW'(cnt - WO_B);
        end else if (cnt >= WV_B) begin
            seg = SEG_WV;
            idx = IW'(cnt - WV_B);
        end else if (cnt >= WK_B) begin
            seg = SEG_WK;
            idx = IW'(cnt - WK_B);
        end else if (cnt >= WQ_B) begin
            seg = SEG_WQ;
            idx = IW'(cnt - WQ_B);
        end else begin
            seg = SEG_X;
            idx = IW'(cnt);
        end
    end

endmodule

// File: rtl/attn_stream_host.sv
// Stream-to-core bridge: loads one job of words into the core operand arrays,
// kicks the core, captures its result and streams the result back out.
module attn_stream_host
    import attn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 8,
    parameter int E          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  core_start,
    input  logic                  core_done,
    output logic [DATA_WIDTH-1:0] x_out    [0:L*E-1],
    output logic [DATA_WIDTH-1:0] wq_out   [0:E*E-1],
    output logic [DATA_WIDTH-1:0] wk_out   [0:E*E-1],
    output logic [DATA_WIDTH-1:0] wv_out   [0:E*E-1],
    output logic [DATA_WIDTH-1:0] wo_out   [0:E*E-1],
    input  logic [DATA_WIDTH-1:0] core_out [0:L*E-1],
    output logic                  busy,
    output logic                  err_len
);

    localparam int N_IN = n_in(L, E);
    localparam int CW   = $clog2(N_IN + 1);
    localparam int IW   = $clog2((L * E > E * E) ? L * E : E * E);
    localparam int OW   = $clog2(L * E);

    localparam logic [CW-1:0] LAST_BEAT = CW'(N_IN - 1);
    localparam logic [OW-1:0] LAST_OUT  = OW'(L * E - 1);

    host_state_t           state_r;
    logic [CW-1:0]         cnt_r;
    logic [OW-1:0]         out_idx_r;
    logic [DATA_WIDTH-1:0] result_r [0:L*E-1];

    seg_t                  seg_s;
    logic [IW-1:0]         idx_s;
    logic                  wr_en_s;
    logic                  cap_en_s;

    assign wr_en_s  = (state_r == S_LOAD) && s_valid && s_ready;
    assign cap_en_s = (state_r == S_WAIT) && core_done;

    attn_seg_decode #(
        .L  (L),
        .E  (E),
        .CW (CW),
        .IW (IW)
    ) u_seg_decode (
        .cnt (cnt_r),
        .seg (seg_s),
        .idx (idx_s)
    );

    // Operand arrays take accepted load beats; result buffer snapshots core_out on done.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L * E; i++) begin
                x_out[i]    <= '0;
                result_r[i] <= '0;
            end
            for (int i = 0; i < E * E; i++) begin
                wq_out[i] <= '0;
                wk_out[i] <= '0;
                wv_out[i] <= '0;
                wo_out[i] <= '0;
            end
        end else begin
            if (wr_en_s) begin
                case (seg_s)
                    SEG_X:   x_out[idx_s]  <= s_data;
                    SEG_WQ:  wq_out[idx_s] <= s_data;
                    SEG_WK:  wk_out[idx_s] <= s_data;
                    SEG_WV:  wv_out[idx_s] <= s_data;
                    SEG_WO:  wo_out[idx_s] <= s_data;
                    default: ;
                endcase
            end
            if (cap_en_s) begin
                result_r <= core_out;
            end
        end
    end

    // Job sequencer with all handshake and status outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_LOAD;
            cnt_r      <= '0;
            out_idx_r  <= '0;
            s_ready    <= 1'b1;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_data     <= '0;
            core_start <= 1'b0;
            busy       <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            case (state_r)
                S_LOAD: begin
                    if (wr_en_s) begin
                        if (cnt_r == LAST_BEAT) begin
                            // Full job received; a missing s_last is flagged but not fatal.
                            if (!s_last) begin
                                err_len <= 1'b1;
                            end
                            cnt_r      <= '0;
                            state_r    <= S_START;
                            s_ready    <= 1'b0;
                            core_start <= 1'b1;
                            busy       <= 1'b1;
                        end else if (s_last) begin
                            // Short job: drop it and wait for a fresh one.
                            err_len <= 1'b1;
                            cnt_r   <= '0;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                end
                S_START: begin
                    core_start <= 1'b0;
                    state_r    <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        state_r   <= S_STREAM;
                        out_idx_r <= '0;
                        m_valid   <= 1'b1;
                        m_data    <= core_out[0];
                        m_last    <= (LAST_OUT == '0);
                    end
                end
                S_STREAM: begin
                    if (m_ready) begin
                        if (out_idx_r == LAST_OUT) begin
                            state_r   <= S_LOAD;
                            out_idx_r <= '0;
                            cnt_r     <= '0;
                            m_valid   <= 1'b0;
                            m_last    <= 1'b0;
                            m_data    <= '0;
                            s_ready   <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            out_idx_r <= out_idx_r + OW'(1);
                            m_data    <= result_r[out_idx_r + OW'(1)];
                            m_last    <= ((out_idx_r + OW'(1)) == LAST_OUT);
                        end
                    end
                end
                default: begin
                    state_r    <= S_LOAD;
                    cnt_r      <= '0;
                    out_idx_r  <= '0;
                    s_ready    <= 1'b1;
                    m_valid    <= 1'b0;
                    m_last     <= 1'b0;
                    m_data     <= '0;
                    core_start <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/attn_stream_host.md
Name: attn_stream_host

Overview:
Host-side bridge that drives the parallel start/done interface of the self-attention core from a simple valid/ready word stream.
- Deserialises one job into x, WQ, WK, WV and WO register arrays, pulses the core start, waits for core done, captures the (L,E) result and serialises it out.
- Sits between the system DMA/stream fabric and the attention core.

Parameters:
DATA_WIDTH, 16, word width (Q1.15)
L, 8, sequence length
E, 8, embedding dimension

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid&s_ready
s_data  in  DATA_WIDTH  input word
s_last  in  1  marks final word of a job
m_valid  out  1  result word valid
m_ready  in  1  downstream accepts result word
m_data  out  DATA_WIDTH  result word
m_last  out  1  marks final result word
core_start  out  1  one-cycle start pulse to core
core_done  in  1  one-cycle done pulse from core
x_out  out  DATA_WIDTH x L*E  to core x_in
wq_out, wk_out, wv_out, wo_out  out  DATA_WIDTH x E*E each  to core weight inputs
core_out  in  DATA_WIDTH x L*E  core result, valid in the core_done cycle
busy  out  1  high in any state but S_LOAD
err_len  out  1  sticky framing error flag

Behaviour:
- Reset (rst high at a clk edge): state S_LOAD, word counter 0, s_ready=1, m_valid=0, m_last=0, m_data=0, core_start=0, busy=0, err_len=0, all weight/x/result arrays 0.
- N_IN = L*E + 4*E*E (320 at defaults). Load order: x row-major, then WQ, WK, WV, WO, each row-major. Counter width $clog2(N_IN+1).
- S_LOAD: s_ready=1. Each handshake writes s_data into the array slot selected by the counter, then increments the counter.
  - Beat N_IN-1 with s_last=1: go to S_START.
  - Beat N_IN-1 with s_last=0: set err_len and still go to S_START.
  - s_last=1 on an earlier beat: that word is written, err_len is set, counter resets to 0, state stays S_LOAD. Partial data is left in the arrays and overwritten by the next job.
- S_START: s_ready=0, core_start=1 for exactly this cycle, then S_WAIT. core_start is high in the cycle after the final accepted beat.
- S_WAIT: s_ready=0, arrays held stable. On core_done, capture all of core_out into the result buffer in that cycle, then go to S_STREAM.
- core_done outside S_WAIT is ignored.
- S_STREAM: m_valid=1 from the first cycle after the capture cycle.
  - m_data = result[idx], idx from 0 to L*E-1.
  - m_data and m_last are held stable while m_valid&!m_ready.
  - m_last=1 only for idx=L*E-1.
  - On the handshake of the last word: m_valid=0 next cycle, counter cleared, return to S_LOAD.
- s_ready is a registered function of state only. It never depends combinationally on s_valid. m_valid does not depend on m_ready.
- err_len clears only on rst.
- rst during any state aborts the job immediately: all outputs return to their reset values and any pending core_done is ignored.
- No arithmetic is performed. The data path is transparent and DATA_WIDTH bits wide.

Decomposition:
- Shared package attn_pkg: typedef enum host_state_t {S_LOAD, S_START, S_WAIT, S_STREAM}, localparam function n_in(L,E), and the load-segment base offsets (X_BASE=0, WQ_BASE=L*E, WK_BASE=WQ_BASE+E*E, and so on).
- One natural sub-module: attn_seg_decode. It is combinational and maps the load counter to a segment select and an in-segment index, so the write mux stays out of the FSM.

Test Plan:
- Single job: stream 320 words with value = beat index and s_last on beat 319, with a core model returning out[i]=16'h1000+i after 5 cycles. Required: x_out[0]=0, wq_out[0]=64, wo_out[63]=319; core_start pulses once, 1 cycle after beat 319; 64 output words 16'h1000..16'h103F; m_last only on 16'h103F; busy=0 afterwards.
- Output backpressure: toggle m_ready 1/0 each cycle. Required: each word held until accepted, no word lost or duplicated, sequence still 16'h1000..16'h103F.
- Early s_last on beat 10. Required: err_len=1, no core_start. A following correct 320-beat job then completes normally and err_len stays 1.
- Missing s_last on beat 319. Required: err_len=1, core_start still pulses and the job completes.
- Spurious core_done during S_LOAD and during S_STREAM. Required: no state change and no result buffer change.
- rst asserted for 1 cycle while in S_WAIT. Required: the next cycle shows s_ready=1, busy=0, m_valid=0, err_len=0. A later core_done produces no output.
